// File: rtl/alu_issue_decoder.sv
// RV32I decode/issue stage feeding the ALU. A combinational decode goes into a
// 2-entry elastic buffer (main + skid) with valid/ready handshakes on both sides.
module alu_issue_decoder #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      ALU_Control,
  output logic [XLEN-1:0] oprand_1,
  output logic [XLEN-1:0] oprand_2,
  output logic [XLEN-1:0] rs_data_in_1,
  output logic [XLEN-1:0] rs_data_in_2,
  output logic [4:0]      rd_addr,
  output logic            rd_we,
  output logic            is_branch,
  output logic            illegal
);

  typedef struct packed {
    logic [3:0]      ctrl;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] rsd1;
    logic [XLEN-1:0] rsd2;
    logic [4:0]      rd;
    logic            we;
    logic            br;
    logic            ill;
  } entry_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [6:0]  opcode_s;
  logic [2:0]  f3_s;
  logic [6:0]  f7_s;
  logic [31:0] imm_i_s;
  logic [31:0] imm_s_s;
  logic [31:0] imm_b_s;
  logic [31:0] imm_u_s;
  logic        writes_s;
  entry_t      dec_s;

  entry_t      main_r;
  entry_t      skid_r;
  logic        main_valid_r;
  logic        skid_valid_r;
  logic        in_xfer_s;
  logic        out_xfer_s;

  assign opcode_s = instr[6:0];
  assign f3_s     = instr[14:12];
  assign f7_s     = instr[31:25];
  assign imm_i_s  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b_s  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u_s  = {instr[31:12], 12'd0};

  // Instruction decode; anything not explicitly matched stays an illegal, zeroed entry
  always_comb begin
    dec_s      = '0;
    dec_s.ill  = 1'b1;
    dec_s.rsd1 = rs1_data;
    dec_s.rsd2 = rs2_data;
    dec_s.rd   = instr[11:7];
    writes_s   = 1'b0;
    case (opcode_s)
      OPC_OP: begin
        if (f7_s == F7_ZERO) begin
          dec_s.ctrl = {1'b0, f3_s};
          dec_s.ill  = 1'b0;
        end else if ((f7_s == F7_ALT) && (f3_s == 3'b000)) begin
          dec_s.ctrl = 4'b1010;
          dec_s.ill  = 1'b0;
        end else if ((f7_s == F7_ALT) && (f3_s == 3'b101)) begin
          dec_s.ctrl = 4'b1011;
          dec_s.ill  = 1'b0;
        end else begin
          dec_s.ill  = 1'b1;
        end
        if (!dec_s.ill) begin
          dec_s.op1 = rs1_data;
          dec_s.op2 = rs2_data;
          writes_s  = 1'b1;
        end else begin
          writes_s  = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        if ((f3_s == 3'b001) && (f7_s == F7_ZERO)) begin
          dec_s.ctrl = 4'b0001;
          dec_s.op2  = XLEN'(instr[24:20]);
          dec_s.ill  = 1'b0;
        end else if ((f3_s == 3'b101) && ((f7_s == F7_ZERO) || (f7_s == F7_ALT))) begin
          dec_s.ctrl = (f7_s == F7_ALT) ? 4'b1011 : 4'b0101;
          dec_s.op2  = XLEN'(instr[24:20]);
          dec_s.ill  = 1'b0;
        end else if ((f3_s != 3'b001) && (f3_s != 3'b101)) begin
          dec_s.ctrl = {1'b0, f3_s};
          dec_s.op2  = XLEN'($signed(imm_i_s));
          dec_s.ill  = 1'b0;
        end else begin
          dec_s.ill  = 1'b1;
        end
        if (!dec_s.ill) begin
          dec_s.op1 = rs1_data;
          writes_s  = 1'b1;
        end else begin
          writes_s  = 1'b0;
        end
      end
      OPC_LUI: begin
        dec_s.ctrl = 4'b0000;
        dec_s.op2  = XLEN'($signed(imm_u_s));
        dec_s.ill  = 1'b0;
        writes_s   = 1'b1;
      end
      OPC_AUIPC: begin
        dec_s.ctrl = 4'b0000;
        dec_s.op1  = pc;
        dec_s.op2  = XLEN'($signed(imm_u_s));
        dec_s.ill  = 1'b0;
        writes_s   = 1'b1;
      end
      OPC_LOAD: begin
        dec_s.ctrl = 4'b0000;
        dec_s.op1  = rs1_data;
        dec_s.op2  = XLEN'($signed(imm_i_s));
        dec_s.ill  = 1'b0;
        writes_s   = 1'b1;
      end
      OPC_STORE: begin
        dec_s.ctrl = 4'b0000;
        dec_s.op1  = rs1_data;
        dec_s.op2  = XLEN'($signed(imm_s_s));
        dec_s.ill  = 1'b0;
      end
      OPC_BRANCH: begin
        if ((f3_s == 3'b010) || (f3_s == 3'b011)) begin
          dec_s.ill  = 1'b1;
        end else begin
          // Branch codes are simply 1 followed by funct3
          dec_s.ctrl = {1'b1, f3_s};
          dec_s.op1  = pc;
          dec_s.op2  = XLEN'($signed(imm_b_s));
          dec_s.br   = 1'b1;
          dec_s.ill  = 1'b0;
        end
      end
      default: begin
        dec_s.ill = 1'b1;
      end
    endcase
    dec_s.we = writes_s && (dec_s.rd != 5'd0);
  end

  assign in_xfer_s  = in_valid && !skid_valid_r;
  assign out_xfer_s = main_valid_r && out_ready;

  // Elastic buffer: main drives the outputs, skid holds the entry that arrives during a stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_r       <= '0;
      skid_r       <= '0;
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (flush) begin
      main_r       <= '0;
      skid_r       <= '0;
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
    end else begin
      case ({main_valid_r, skid_valid_r})
        2'b00: begin
          if (in_xfer_s) begin
            main_r       <= dec_s;
            main_valid_r <= 1'b1;
          end
        end
        2'b10: begin
          if (in_xfer_s && out_xfer_s) begin
            main_r <= dec_s;
          end else if (out_xfer_s) begin
            main_valid_r <= 1'b0;
          end else if (in_xfer_s) begin
            skid_r       <= dec_s;
            skid_valid_r <= 1'b1;
          end
        end
        2'b11: begin
          if (out_xfer_s) begin
            main_r       <= skid_r;
            skid_valid_r <= 1'b0;
          end
        end
        default: begin
          main_valid_r <= 1'b0;
          skid_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = !skid_valid_r;
  assign out_valid    = main_valid_r;
  assign ALU_Control  = main_r.ctrl;
  assign oprand_1     = main_r.op1;
  assign oprand_2     = main_r.op2;
  assign rs_data_in_1 = main_r.rsd1;
  assign rs_data_in_2 = main_r.rsd2;
  assign rd_addr      = main_r.rd;
  assign rd_we        = main_r.we;
  assign is_branch    = main_r.br;
  assign illegal      = main_r.ill;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Bench for alu_issue_decoder: directed vector table, hand-written handshake
// sequences, then random traffic checked against a queue-based reference model.
module tb_alu_issue_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = 32'd0;
  logic [31:0] pc = 32'd0;
  logic [31:0] rs1_data = 32'd0;
  logic [31:0] rs2_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  ALU_Control;
  logic [31:0] oprand_1;
  logic [31:0] oprand_2;
  logic [31:0] rs_data_in_1;
  logic [31:0] rs_data_in_2;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic        is_branch;
  logic        illegal;

  int total = 0;
  int bad = 0;

  alu_issue_decoder #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALU_Control(ALU_Control), .oprand_1(oprand_1), .oprand_2(oprand_2),
    .rs_data_in_1(rs_data_in_1), .rs_data_in_2(rs_data_in_2),
    .rd_addr(rd_addr), .rd_we(rd_we), .is_branch(is_branch), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  rd;
    logic        we;
    logic        br;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pcv;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd;
    logic        we;
    logic        br;
    logic        ill;
  } vec_t;

  vec_t vecs[14];
  exp_t sb[$];

  function automatic exp_t actual();
    exp_t r;
    r = {ALU_Control, oprand_1, oprand_2, rs_data_in_1, rs_data_in_2, rd_addr, rd_we, is_branch, illegal};
    return r;
  endfunction

  // Reference decode written from the instruction-set rules using integer arithmetic
  function automatic exp_t ref_decode(logic [31:0] ins, logic [31:0] pcv, logic [31:0] a, logic [31:0] b);
    exp_t r;
    int f3, f7, opc, si;
    logic legal, wr;
    logic [31:0] imm_i, imm_s, imm_b, imm_u;
    opc = int'(ins[6:0]);
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    si = int'(ins);
    imm_i = 32'(si >>> 20);
    imm_s = 32'((si >>> 25) << 5) | 32'(ins[11:7]);
    imm_b = 32'((si >>> 31) << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
    imm_u = ins & 32'hFFFFF000;
    r = '0;
    r.r1 = a;
    r.r2 = b;
    r.rd = ins[11:7];
    legal = 1'b0;
    wr = 1'b0;
    case (opc)
      'h33: begin
        legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
        r.ctrl = (f7 == 0) ? 4'(f3) : ((f3 == 0) ? 4'd10 : 4'd11);
        r.op1 = a; r.op2 = b; wr = 1'b1;
      end
      'h13: begin
        r.op1 = a; wr = 1'b1;
        if (f3 == 1) begin
          legal = (f7 == 0); r.ctrl = 4'd1; r.op2 = 32'(ins[24:20]);
        end else if (f3 == 5) begin
          legal = (f7 == 0) || (f7 == 32); r.ctrl = (f7 == 32) ? 4'd11 : 4'd5; r.op2 = 32'(ins[24:20]);
        end else begin
          legal = 1'b1; r.ctrl = 4'(f3); r.op2 = imm_i;
        end
      end
      'h37: begin legal = 1'b1; r.op2 = imm_u; wr = 1'b1; end
      'h17: begin legal = 1'b1; r.op1 = pcv; r.op2 = imm_u; wr = 1'b1; end
      'h03: begin legal = 1'b1; r.op1 = a; r.op2 = imm_i; wr = 1'b1; end
      'h23: begin legal = 1'b1; r.op1 = a; r.op2 = imm_s; end
      'h63: begin
        legal = (f3 != 2) && (f3 != 3);
        r.ctrl = 4'(8 + f3); r.op1 = pcv; r.op2 = imm_b; r.br = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      r.ctrl = 4'd0; r.op1 = 32'd0; r.op2 = 32'd0; r.br = 1'b0; wr = 1'b0;
    end
    r.ill = !legal;
    r.we = wr && (r.rd != 5'd0);
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    logic [6:0] opcs [8];
    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h7F};
    ins = $urandom;
    if ($urandom_range(0, 9) != 0) ins[6:0] = opcs[$urandom_range(0, 7)];
    if ($urandom_range(0, 3) != 0) ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return ins;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bit(string name, logic act, logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  task automatic chk_entry(string name, exp_t req);
    exp_t act;
    act = actual();
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got ctrl=%h op1=%h op2=%h r1=%h r2=%h rd=%0d we=%b br=%b ill=%b expected ctrl=%h op1=%h op2=%h r1=%h r2=%h rd=%0d we=%b br=%b ill=%b",
               name, act.ctrl, act.op1, act.op2, act.r1, act.r2, act.rd, act.we, act.br, act.ill,
               req.ctrl, req.op1, req.op2, req.r1, req.r2, req.rd, req.we, req.br, req.ill);
    end
  endtask

  task automatic offer(logic [31:0] ins, logic [31:0] pcv, logic [31:0] a, logic [31:0] b);
    in_valid = 1'b1; instr = ins; pc = pcv; rs1_data = a; rs2_data = b;
  endtask

  initial begin
    exp_t e;
    // ins, pc, rs1, rs2, ctrl, op1, op2, rd, we, br, ill
    vecs[0]  = '{32'h002081B3, 32'h0, 32'h00000001, 32'h40000001, 4'h0, 32'h00000001, 32'h40000001, 5'd3, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{32'h4080D293, 32'h0, 32'h88104225, 32'h0, 4'hB, 32'h88104225, 32'h00000008, 5'd5, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{32'h00208463, 32'h88104225, 32'h11, 32'h22, 4'h8, 32'h88104225, 32'h00000008, 5'd8, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{32'hFFFFFFFF, 32'h44, 32'h55, 32'h66, 4'h0, 32'h0, 32'h0, 5'd31, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{32'h123453B7, 32'h8, 32'h9, 32'hA, 4'h0, 32'h0, 32'h12345000, 5'd7, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{32'hFFFFF097, 32'h1000, 32'h9, 32'hA, 4'h0, 32'h1000, 32'hFFFFF000, 5'd1, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{32'hFE20AE23, 32'h0, 32'h100, 32'h77, 4'h0, 32'h100, 32'hFFFFFFFC, 5'd28, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{32'h0100A003, 32'h0, 32'h200, 32'h0, 4'h0, 32'h200, 32'h10, 5'd0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{32'h40628233, 32'h0, 32'd10, 32'd3, 4'hA, 32'd10, 32'd3, 5'd4, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{32'h40629233, 32'h0, 32'd10, 32'd3, 4'h0, 32'h0, 32'h0, 5'd4, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{32'h0020A463, 32'h80, 32'h1, 32'h2, 4'h0, 32'h0, 32'h0, 5'd8, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{32'h40809293, 32'h0, 32'h1, 32'h2, 4'h0, 32'h0, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{32'hFFF00093, 32'h0, 32'h5, 32'h6, 4'h0, 32'h5, 32'hFFFFFFFF, 5'd1, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{32'hFE209EE3, 32'h100, 32'h3, 32'h4, 4'h9, 32'h100, 32'hFFFFFFFC, 5'd29, 1'b0, 1'b1, 1'b0};

    #12;
    chk_bit("reset out_valid", out_valid, 1'b0);
    chk_bit("reset in_ready", in_ready, 1'b1);
    chk_entry("reset payload", exp_t'(0));
    #10 rst = 1'b1;
    step();

    // Directed decode table, one instruction at a time
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      offer(vecs[i].ins, vecs[i].pcv, vecs[i].a, vecs[i].b);
      step();
      in_valid = 1'b0;
      chk_bit($sformatf("vec%0d out_valid", i), out_valid, 1'b1);
      e = {vecs[i].ctrl, vecs[i].op1, vecs[i].op2, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].we, vecs[i].br, vecs[i].ill};
      chk_entry($sformatf("vec%0d", i), e);
      step();
    end

    // Backpressure: A, B fill the buffer; C waits until the skid drains
    out_ready = 1'b0;
    offer(32'h00100093, 32'h0, 32'h0, 32'h0);
    step();
    chk_bit("bp in_ready after A", in_ready, 1'b1);
    offer(32'h00200113, 32'h0, 32'h0, 32'h0);
    step();
    chk_bit("bp in_ready after B", in_ready, 1'b0);
    offer(32'h00300193, 32'h0, 32'h0, 32'h0);
    step();
    step();
    chk_bit("bp stall out_valid", out_valid, 1'b1);
    chk_bit("bp stall in_ready", in_ready, 1'b0);
    chk_bit("bp stall holds A", rd_addr == 5'd1, 1'b1);
    out_ready = 1'b1;
    step();
    chk_bit("bp order B", rd_addr == 5'd2, 1'b1);
    chk_bit("bp in_ready reopened", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chk_bit("bp order C", rd_addr == 5'd3, 1'b1);
    chk_bit("bp C valid", out_valid, 1'b1);
    step();
    chk_bit("bp drained", out_valid, 1'b0);

    // Flush at occupancy 1 drops the same-cycle input
    out_ready = 1'b0;
    offer(32'h00400213, 32'h0, 32'h0, 32'h0);
    step();
    offer(32'h00500293, 32'h0, 32'h0, 32'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk_bit("flush out_valid", out_valid, 1'b0);
    chk_bit("flush in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    step();
    chk_bit("flush input dropped", out_valid, 1'b0);

    // Reset mid-stream with occupancy 2
    out_ready = 1'b0;
    offer(32'h00600313, 32'h0, 32'h3, 32'h0);
    step();
    offer(32'h00700393, 32'h0, 32'h4, 32'h0);
    step();
    in_valid = 1'b0;
    chk_bit("pre-reset full", in_ready, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk_bit("async reset out_valid", out_valid, 1'b0);
    chk_entry("async reset payload", exp_t'(0));
    step();
    rst = 1'b1;
    step();
    chk_bit("post-reset in_ready", in_ready, 1'b1);
    chk_bit("post-reset out_valid", out_valid, 1'b0);

    // Random traffic against the queue model
    for (int c = 0; c < 3000; c++) begin
      logic iv, orr, fl, ix, ox;
      logic [31:0] ins, pcv, a, b;
      chk_bit("rnd out_valid", out_valid, sb.size() > 0);
      chk_bit("rnd in_ready", in_ready, sb.size() < 2);
      iv = ($urandom_range(0, 9) < 7);
      orr = ($urandom_range(0, 9) < 6);
      fl = ($urandom_range(0, 29) == 0);
      ins = rand_instr();
      pcv = $urandom; a = $urandom; b = $urandom;
      in_valid = iv; out_ready = orr; flush = fl;
      instr = ins; pc = pcv; rs1_data = a; rs2_data = b;
      ix = iv && (sb.size() < 2);
      ox = orr && (sb.size() > 0);
      if (ox) begin
        chk_entry("rnd payload", sb[0]);
        void'(sb.pop_front());
      end
      if (fl) sb.delete();
      else if (ix) sb.push_back(ref_decode(ins, pcv, a, b));
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_decoder.md
Name: alu_issue_decoder

Overview:
Decode/issue stage that drives the ALU's control and operand inputs. It turns a fetched RV32I instruction, its PC and its register-file read data into ALU_Control, oprand_1, oprand_2, rs_data_in_1 and rs_data_in_2. Output is registered behind a 2-entry elastic buffer with valid/ready handshakes on both sides. It sits between fetch/register-read and the ALU.

Parameters:
XLEN, 32, datapath width for PC, operands and immediates.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset
flush  input  1  synchronous; discards all buffered entries
in_valid  input  1  instruction/pc/rs data valid
in_ready  output  1  stage can accept this cycle
instr  input  32  RV32I instruction word
pc  input  XLEN  address of instr
rs1_data  input  XLEN  register-file read of instr[19:15]
rs2_data  input  XLEN  register-file read of instr[24:20]
out_valid  output  1  issued entry valid
out_ready  input  1  ALU side accepts entry
ALU_Control  output  4  ALU operation code
oprand_1  output  XLEN  ALU operand 1
oprand_2  output  XLEN  ALU operand 2
rs_data_in_1  output  XLEN  branch compare data 1 (rs1_data)
rs_data_in_2  output  XLEN  branch compare data 2 / store data (rs2_data)
rd_addr  output  5  destination register
rd_we  output  1  write-back enable
is_branch  output  1  entry is a conditional branch
illegal  output  1  unsupported encoding

Behaviour:
- rst low: buffer empty; out_valid=0; all payload outputs 0; in_ready=1. State is held while rst is low.
- Handshake: an input transfer occurs when in_valid&in_ready; an output transfer occurs when out_valid&out_ready.
- While out_valid=1 and out_ready=0, the payload holds stable.
- Buffer: main register (drives outputs) plus skid register. Occupancy is 0..2.
- in_ready = !skid_valid, taken directly from a flop with no comb path from out_ready.
- Latency: 1 cycle from input transfer to out_valid when the buffer is empty.
- Entries issue in order, with no loss or duplication.
- Simultaneous input and output transfer at occupancy 1: main register reloads and occupancy stays 1.
- At occupancy 2: the output transfer moves skid into main.
- flush: next cycle occupancy=0 and out_valid=0. flush has priority over a same-cycle input transfer; that input is dropped and counts as consumed. rst low overrides flush.
- ALU_Control codes: add 0000, sll 0001, slt 0010, sltu 0011, xor 0100, srl 0101, or 0110, and 0111, beq 1000, bne 1001, sub 1010, sra 1011, blt 1100, bge 1101, bltu 1110, bgeu 1111.
- OP (0110011): f7=0000000 with any f3 maps to the codes above. f7=0100000 is legal only with f3=000 (sub) and f3=101 (sra). oprand_1=rs1_data, oprand_2=rs2_data.
- OP-IMM (0010011): I-immediate sign-extended; oprand_1=rs1_data, oprand_2=imm.
  - Shifts (f3=001 and f3=101): oprand_2={27'b0, instr[24:20]}.
  - slli requires instr[31:25]=0.
  - srli/srai require instr[31:25]=0000000 or 0100000 respectively.
- LUI: add; oprand_1=0, oprand_2={instr[31:12],12'b0}.
- AUIPC: add; oprand_1=pc, oprand_2=U-immediate.
- LOAD/STORE: add; oprand_1=rs1_data, oprand_2=I/S-immediate sign-extended.
  - LOAD sets rd_we=1.
  - STORE sets rd_we=0.
- BRANCH: f3 000/001/100/101/110/111 map to beq/bne/blt/bge/bltu/bgeu; f3 010/011 are illegal.
  - oprand_1=pc, oprand_2=B-immediate sign-extended (bit0=0).
  - is_branch=1, rd_we=0.
- rs_data_in_1/2 always carry rs1_data/rs2_data.
- rd_addr=instr[11:7]; rd_we is forced to 0 when rd_addr=0.
- Illegal (any other opcode or bad funct): issues with illegal=1, ALU_Control=0000, oprands 0, rd_we=0, is_branch=0.

Test Plan:
- Reset: rst=0 mid-stream with occupancy 2 -> immediately out_valid=0 and outputs 0; after release, in_ready=1.
- add x3,x1,x2 (0x002081B3), rs1=0x00000001, rs2=0x40000001, out_ready=1 -> next cycle out_valid=1, ALU_Control=0000, oprand_1=0x00000001, oprand_2=0x40000001, rd_addr=3, rd_we=1.
- srai x5,x1,8 (0x4080D293), rs1=0x88104225 -> ALU_Control=1011, oprand_1=0x88104225, oprand_2=0x00000008, rd_we=1.
- beq x1,x2,+8 (0x00208463), pc=0x88104225 -> ALU_Control=1000, oprand_1=0x88104225, oprand_2=0x00000008, is_branch=1, rd_we=0, rs_data_in_1/2 = rs1/rs2.
- Backpressure: out_ready=0, offer 3 instructions -> first two accepted, in_ready=0 from the cycle after the second; with out_ready=1 the outputs appear in order A, B, C, one per cycle.
- flush asserted with in_valid=1 at occupancy 1 -> next cycle out_valid=0 and the input is dropped. Separately, instr 0xFFFFFFFF -> illegal=1, ALU_Control=0000, rd_we=0.
